// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue types and core-level sizing constant.
package fetch_queue_pkg;

  localparam int FETCHQ_DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with redirect flush.
// Optional FETCHQ_BYPASS_EN: zero-latency pass-through when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FETCHQ_DEPTH,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t           mem [DEPTH];
  fetch_entry_t           head;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       cnt;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   bypass_take;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != CNT_W'(DEPTH));
  assign count    = cnt;
  assign head     = mem[rd_ptr];

`ifdef FETCHQ_BYPASS_EN
  // An entry consumed straight from the input never touches storage.
  assign bypass_take = empty & in_valid & out_ready & ~flush;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid & in_ready & ~flush & ~bypass_take;
  assign pop  = ~empty & out_ready & ~flush;

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_pc    = PC_W'(head.pc);
      out_instr = INST_W'(head.instr);
    end
`ifdef FETCHQ_BYPASS_EN
    else if (in_valid && !flush) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: 64'(in_pc), instr: 32'(in_instr)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build or FETCHQ_BYPASS_EN).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [31:0] instr);
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_pc !== 64'd0 || out_instr !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_pc, out_instr); end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push_one(64'h7000_0000 + 64'(i * 4), 32'h700 + 32'(i));
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL reset_prefill_count got=%0d exp=3", count); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_midrun got count=%0d ov=%b ir=%b exp 0/0/1", count, out_valid, in_ready);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(64'h8000_0000 + 64'(i * 4), 32'h1000 + 32'(i));
      checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 + 64'(i * 4) || out_instr !== 32'h1000 + 32'(i)) begin
        failures++; $display("FAIL drain[%0d] got ov=%b pc=%h instr=%h exp 1/%h/%h", i, out_valid, out_pc, out_instr,
                             64'h8000_0000 + 64'(i * 4), 32'h1000 + 32'(i));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL drain_empty got ov=%b count=%0d exp 0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq [$];
    logic [63:0] e;
    out_ready = 1'b0;
    push_one(64'h8000_00A0, 32'hA0); expq.push_back(64'h8000_00A0);
    push_one(64'h8000_00A4, 32'hA4); expq.push_back(64'h8000_00A4);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_pc = 64'h8000_00A8 + 64'(i * 4); in_instr = 32'hA8 + 32'(i * 4);
      e = expq.pop_front();
      expq.push_back(in_pc);
      checks++; if (out_pc !== e || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_head[%0d] got ov=%b pc=%h exp 1/%h", i, out_valid, out_pc, e); end
      tick();
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = expq.pop_front();
      checks++; if (out_pc !== e) begin failures++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", i, out_pc, e); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got ov=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(64'h8000_0050 + 64'(i * 4), 32'h50 + 32'(i));
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0EEE; in_instr = 32'hEEE; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 64'd0) begin
      failures++; $display("FAIL flush_clear got count=%0d ov=%b pc=%h exp 0/0/0", count, out_valid, out_pc);
    end
    push_one(64'h8000_0100, 32'h100);
    checks++; if (count !== 3'd1 || out_pc !== 64'h8000_0100 || out_instr !== 32'h100) begin
      failures++; $display("FAIL flush_repush got count=%0d pc=%h instr=%h exp 1/80000100/100", count, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_pop got ov=%b exp=0", out_valid); end
  endtask

  task automatic test_full_drop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(64'h8000_00C0 + 64'(i * 4), 32'hC0 + 32'(i));
    push_one(64'h8000_0DEA, 32'hDEAD_BEEF);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_drop_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== 64'h8000_00C0 + 64'(i * 4) || out_instr !== 32'hC0 + 32'(i)) begin
        failures++; $display("FAIL full_drop_pop[%0d] got pc=%h instr=%h exp %h/%h", i, out_pc, out_instr,
                             64'h8000_00C0 + 64'(i * 4), 32'hC0 + 32'(i));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_drop_empty got ov=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_bypass();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0200; in_instr = 32'h0000_0013;
    #1;
`ifdef FETCHQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_0013) begin
      failures++; $display("FAIL bypass_same got ov=%b instr=%h exp 1/00000013", out_valid, out_instr);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bypass_count got count=%0d ov=%b exp 0/0", count, out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_same got ov=%b exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_0013 || count !== 3'd1) begin
      failures++; $display("FAIL nobypass_next got ov=%b instr=%h count=%0d exp 1/00000013/1", out_valid, out_instr, count);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_pop got ov=%b exp=0", out_valid); end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_drop();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
